// File: rtl/simple_bus_resp_pkg.sv
// simple_bus_resp_pkg: shared state type, default parameters and counter width
package simple_bus_resp_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} sbr_state_t;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_REG_NUM  = 12;
    localparam int DEF_WAIT_CYC = 2;
    localparam int CNT_W        = 8;
endpackage

// File: rtl/simple_bus_resp_rf.sv
// simple_bus_resp_rf: register array with byte-enable writes; out-of-range reads 0
module simple_bus_resp_rf
    import simple_bus_resp_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_NUM = DEF_REG_NUM
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic hit;
    assign hit = int'(addr_i) < REG_NUM;
    assign rdata_o = hit ? regs_q[addr_i] : '0;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
        end else if (wr_en_i && hit) begin
            for (int b = 0; b < DATA_W/8; b++)
                if (be_i[b]) regs_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end
endmodule

// File: rtl/simple_bus_resp.sv
// simple_bus_resp: register-file bus responder with WAIT_CYC wait states.
// Define SIMPLE_BUS_RESP_ERR_EN to add the resp_err out-of-range flag.
module simple_bus_resp
    import simple_bus_resp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int REG_NUM  = DEF_REG_NUM,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_vld,
    output logic                req_rdy,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_vld,
    input  logic                resp_rdy,
    output logic [DATA_W-1:0]   resp_rdata
`ifdef SIMPLE_BUS_RESP_ERR_EN
    ,
    output logic                resp_err
`endif
);
    sbr_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic en_q;
    logic we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d, rf_rdata;
    logic [DATA_W/8-1:0] be_q;
    logic accept, exec, x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata;
    logic [DATA_W/8-1:0] x_be;

    assign req_rdy    = en_q && state_q == IDLE;
    assign accept     = req_vld && req_rdy;
    assign resp_vld   = state_q == RESP;
    assign resp_rdata = rdata_q;
    // a zero-wait access executes on the accept edge, straight from the request fields
    assign x_we    = state_q == IDLE ? req_we    : we_q;
    assign x_addr  = state_q == IDLE ? req_addr  : addr_q;
    assign x_wdata = state_q == IDLE ? req_wdata : wdata_q;
    assign x_be    = state_q == IDLE ? req_be    : be_q;
    assign rdata_d = exec ? (x_we ? '0 : rf_rdata) : rdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d   = CNT_W'(WAIT_CYC);
                exec    = WAIT_CYC == 0;
                state_d = WAIT_CYC == 0 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    exec    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: if (resp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= 1'b1;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

    simple_bus_resp_rf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .REG_NUM(REG_NUM)
    ) u_rf (
        .clk    (clk),
        .resetn (resetn),
        .wr_en_i(exec && x_we),
        .addr_i (x_addr),
        .wdata_i(x_wdata),
        .be_i   (x_be),
        .rdata_o(rf_rdata)
    );

`ifdef SIMPLE_BUS_RESP_ERR_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!resetn) err_q <= 1'b0;
        else if (exec) err_q <= int'(x_addr) >= REG_NUM;
    end
    assign resp_err = resp_vld && err_q;
`endif
endmodule

// File: tb/tb_simple_bus_resp.sv
// tb_simple_bus_resp: randomized checks of simple_bus_resp against an array model
module tb_simple_bus_resp;
    localparam int W = 2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn = 1'b0;
    logic req_vld = 1'b0, req_we = 1'b0, resp_rdy = 1'b0;
    logic [3:0] req_addr = '0, req_be = '0;
    logic [31:0] req_wdata = '0;
    logic req_rdy, resp_vld;
    logic [31:0] resp_rdata;
    logic z_req_vld = 1'b0, z_req_we = 1'b0, z_resp_rdy = 1'b1;
    logic [3:0] z_req_addr = '0, z_req_be = '0;
    logic [31:0] z_req_wdata = '0;
    logic z_req_rdy, z_resp_vld;
    logic [31:0] z_resp_rdata;
`ifdef SIMPLE_BUS_RESP_ERR_EN
    logic resp_err, z_resp_err;
`endif

    int checks = 0, errors = 0;
    logic [31:0] mdl [16];
    logic [31:0] zmdl [16];

    simple_bus_resp #(.ADDR_W(4), .DATA_W(32), .REG_NUM(12), .WAIT_CYC(W)) dut (
        .clk(clk), .resetn(resetn), .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_vld(resp_vld),
        .resp_rdy(resp_rdy), .resp_rdata(resp_rdata)
`ifdef SIMPLE_BUS_RESP_ERR_EN
        , .resp_err(resp_err)
`endif
    );

    simple_bus_resp #(.ADDR_W(4), .DATA_W(32), .REG_NUM(12), .WAIT_CYC(0)) dut_z (
        .clk(clk), .resetn(resetn), .req_vld(z_req_vld), .req_rdy(z_req_rdy), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be), .resp_vld(z_resp_vld),
        .resp_rdy(z_resp_rdy), .resp_rdata(z_resp_rdata)
`ifdef SIMPLE_BUS_RESP_ERR_EN
        , .resp_err(z_resp_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        merge = old;
        for (int b = 0; b < 4; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 16; i++) begin
            mdl[i] = '0;
            zmdl[i] = '0;
        end
    endtask

    task automatic scramble();
        req_vld   = 1'($urandom);
        req_we    = 1'($urandom);
        req_addr  = 4'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic txn(input logic we, input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be, input int hold);
        logic [31:0] exp, snap;
        int n;
        n = 0;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_rdy_before", 64'(req_rdy), 64'(1));
        exp = (!we && a < 12) ? mdl[a] : 32'h0;
        if (we && a < 12) mdl[a] = merge(mdl[a], wd, be);
        req_vld = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        resp_rdy = hold == 0;
        @(negedge clk);
        n = 1;
        while (!resp_vld && n < 300) begin
            scramble();
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(1 + W));
        snap = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            check("hold_vld", 64'(resp_vld), 64'(1));
            check("hold_rdata", 64'(resp_rdata), 64'(snap));
            check("hold_req_rdy", 64'(req_rdy), 64'(0));
            scramble();
            @(negedge clk);
        end
        req_vld = 1'b0;
        check("rdata", 64'(resp_rdata), 64'(exp));
`ifdef SIMPLE_BUS_RESP_ERR_EN
        check("err", 64'(resp_err), 64'(a >= 12));
`endif
        resp_rdy = 1'b1;
        @(negedge clk);
        check("post_req_rdy", 64'(req_rdy), 64'(1));
        check("post_resp_vld", 64'(resp_vld), 64'(0));
        resp_rdy = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] zexp;
        logic zwe;
        logic [3:0] za;
        logic [31:0] zwd;
        logic [3:0] zbe;
        clear_models();
        zexp = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_resp_vld", 64'(resp_vld), 64'(0));
        check("rst_rdata", 64'(resp_rdata), 64'(0));
        resetn = 1'b1;
        @(negedge clk);
        check("rst_release_rdy", 64'(req_rdy), 64'(1));

        txn(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 4'd3, 32'h0, 4'h0, 0);
        txn(1'b1, 4'd5, 32'h11223344, 4'hF, 1);
        txn(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 2);
        txn(1'b0, 4'd5, 32'h0, 4'h0, 0);
        txn(1'b1, 4'd7, 32'h12345678, 4'h0, 0);
        txn(1'b0, 4'd3, 32'h0, 4'h0, 10);
        txn(1'b0, 4'd14, 32'h0, 4'h0, 0);
        txn(1'b1, 4'd14, 32'hFFFFFFFF, 4'hF, 0);
        for (int i = 0; i < 16; i++) txn(1'b0, 4'(i), 32'h0, 4'h0, 0);

        req_vld = 1'b1; req_we = 1'b1; req_addr = 4'd2; req_wdata = 32'h55; req_be = 4'hF;
        @(negedge clk);
        req_vld = 1'b0;
        check("abort_in_wait", 64'(req_rdy), 64'(0));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        clear_models();
        for (int i = 0; i < 6; i++) begin
            check("abort_no_resp", 64'(resp_vld), 64'(0));
            @(negedge clk);
        end
        txn(1'b0, 4'd2, 32'h0, 4'h0, 0);
        txn(1'b0, 4'd3, 32'h0, 4'h0, 0);

        for (int t = 0; t < 40; t++)
            txn(1'($urandom), 4'($urandom_range(0, 15)), $urandom, 4'($urandom), $urandom_range(0, 3));

        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                check("z_req_rdy_hi", 64'(z_req_rdy), 64'(1));
                zwe = (i < 8) ? 1'b1 : 1'($urandom);
                za  = 4'($urandom_range(0, 4));
                zwd = $urandom;
                zbe = (i < 8) ? 4'hF : 4'($urandom);
                zexp = (!zwe && za < 12) ? zmdl[za] : 32'h0;
                if (zwe && za < 12) zmdl[za] = merge(zmdl[za], zwd, zbe);
                z_req_vld = 1'b1; z_req_we = zwe; z_req_addr = za; z_req_wdata = zwd; z_req_be = zbe;
            end else begin
                check("z_req_rdy_lo", 64'(z_req_rdy), 64'(0));
                check("z_resp_vld", 64'(z_resp_vld), 64'(1));
                check("z_rdata", 64'(z_resp_rdata), 64'(zexp));
                z_req_we = 1'($urandom); z_req_addr = 4'($urandom); z_req_wdata = $urandom;
            end
            @(negedge clk);
        end
        z_req_vld = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_bus_resp.md
SIMPLE_BUS_RESP -- requirements
Module: simple_bus_resp

Interface
REQ-001 Parameter ADDR_W, default 4, sets the request address width in bits.
REQ-002 Parameter DATA_W, default 32, sets the data width in bits; it SHALL be a multiple of 8.
REQ-003 Parameter REG_NUM, default 12, sets the implemented register count; it SHALL not exceed 2**ADDR_W.
REQ-004 Parameter WAIT_CYC, default 2, sets the wait states between request accept and response; the range is 0..255.
REQ-005 The block SHALL use one clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1, is the sole clock; every register updates on its rising edge.
REQ-007 Port resetn, input, 1, is the synchronous active-low reset.
REQ-008 Port req_vld, input, 1, marks the request fields as valid.
REQ-009 Port req_rdy, output, 1, shows the responder can accept a request.
REQ-010 Port req_we, input, 1, selects write when 1 and read when 0.
REQ-011 Port req_addr, input, ADDR_W, is the register index.
REQ-012 Port req_wdata, input, DATA_W, is the write data.
REQ-013 Port req_be, input, DATA_W/8, holds the byte enables for a write.
REQ-014 Port resp_vld, output, 1, marks the response as valid.
REQ-015 Port resp_rdy, input, 1, shows the initiator accepts the response.
REQ-016 Port resp_rdata, output, DATA_W, is the read data; it is 0 for writes.
REQ-017 Port resp_err, output, 1, is the error flag; it exists only under REQ-033.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, RESP.
REQ-019 req_rdy SHALL be 1 only in IDLE; a request is accepted on an edge with req_vld&&req_rdy.
REQ-020 On accept, the block SHALL latch we/addr/wdata/be, load the wait counter with WAIT_CYC, and go to WAIT (or straight to RESP when WAIT_CYC=0).
REQ-021 In WAIT, the counter SHALL decrement once per cycle; on the edge where it reaches 0, the access executes and the state goes to RESP.
REQ-022 resp_vld SHALL rise exactly 1+WAIT_CYC cycles after the accept edge and stay asserted with stable resp_rdata/resp_err until resp_vld&&resp_rdy.
REQ-023 On the response handshake edge, the FSM SHALL return to IDLE; req_rdy is 1 in the following cycle, with no back-to-back accept in the same cycle.
REQ-024 A write SHALL update only the bytes with req_be[i]=1; with be=0 it completes with no register change.
REQ-025 A read SHALL return the register value as it stood at execute time, so a write is visible to any later read.
REQ-026 An address >= REG_NUM SHALL ignore writes and read as 0.
REQ-027 Changes on req_* outside IDLE SHALL be ignored; resp_rdy high outside RESP SHALL have no effect.

Reset
REQ-028 With resetn=0 at an edge, the state SHALL be IDLE, the counter 0, all registers 0, req_rdy=0, resp_vld=0, resp_rdata=0, and resp_err=0.
REQ-029 req_rdy SHALL go to 1 in the first cycle after resetn is sampled high.
REQ-030 Reset during WAIT or RESP SHALL abort the transaction with no register write and no response.

Configuration
REQ-031 The macro SIMPLE_BUS_RESP_ERR_EN SHALL control error reporting.
REQ-032 Without the macro, there is no resp_err port and out-of-range behaviour follows REQ-026.
REQ-033 With the macro, the resp_err port exists; it is 1 in RESP for an out-of-range address and 0 otherwise, while data behaviour stays as in REQ-026.

Structure
REQ-034 The package simple_bus_resp_pkg SHALL hold the state enum typedef sbr_state_t, the default parameter constants, and the WAIT_CYC counter width (8).
REQ-035 The register array and byte-enable write logic SHALL sit in one sub-module, simple_bus_resp_rf, and the FSM, counter and handshake stay in the top module.

Verification
REQ-036 After reset, write addr=3, data=0xDEADBEEF, be=0xF, then read addr=3 -> rdata=0xDEADBEEF and resp_vld rises 3 cycles after each accept (WAIT_CYC=2).
REQ-037 With reg 5=0x11223344, write 0xAABBCCDD with be=0b0101 -> read returns 0x11BB33DD.
REQ-038 Hold resp_rdy=0 for 10 cycles -> resp_vld and rdata stay stable and req_rdy stays 0 throughout.
REQ-039 Read addr=14 (REG_NUM=12) -> rdata=0 and resp_err=1 with the macro defined; a write to addr=14 leaves all registers unchanged.
REQ-040 Pulse resetn low during WAIT of a write to addr 2 with 0x55 -> no response follows and a later read of addr 2 returns 0.
REQ-041 With WAIT_CYC=0, back-to-back requests with resp_rdy tied to 1 -> one transaction every 2 cycles, with correct data.
